// File: rtl/fmap_pkg.sv
// Shared definitions for the output feature-map collector and its window producer.
package fmap_pkg;

    localparam int unsigned DefaultWidth     = 28;
    localparam int unsigned DefaultDataWidth = 18;
    localparam int unsigned DefaultChannels  = 16;

    // Position counters cover output maps up to 63x63 (WIDTH <= 65).
    localparam int unsigned CntWidth = 6;

    typedef logic [CntWidth-1:0] cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_t;

endpackage

// File: rtl/fmap_relu_clamp.sv
// Per-element clamp applied before storage. Macro FMAP_COLLECT_RELU_EN selects ReLU;
// otherwise the element passes through unchanged.
module fmap_relu_clamp
    import fmap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

`ifdef FMAP_COLLECT_RELU_EN
    assign data_o = data_i[DATA_WIDTH-1] ? '0 : data_i;
`else
    assign data_o = data_i;
`endif

endmodule

// File: rtl/fmap_collector.sv
// Collects one channel vector per window position in raster order into a registered map.
// Optional ReLU on stored elements via macro FMAP_COLLECT_RELU_EN.
module fmap_collector
    import fmap_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned CHANNELS   = DefaultChannels
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] pixel_in [0:CHANNELS-1],
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] fmap_out [0:WIDTH-3][0:WIDTH-3][0:CHANNELS-1],
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int   OUT_W   = int'(WIDTH) - 2;
    localparam cnt_t LastPos = cnt_t'(OUT_W - 1);

    state_t state_q;
    cnt_t   x_q;
    cnt_t   y_q;
    logic   ready_q;
    logic   busy_q;
    logic   done_q;
    logic   err_q;

    logic [DATA_WIDTH-1:0] clamped [0:CHANNELS-1];
    logic [DATA_WIDTH-1:0] fmap_q  [0:WIDTH-3][0:WIDTH-3][0:CHANNELS-1];

    logic wr_en;
    assign wr_en = (state_q == StCollect) && i_valid;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_clamp
        fmap_relu_clamp #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_clamp (
            .data_i(pixel_in[c]),
            .data_o(clamped[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Data offered outside COLLECT is dropped; remember it until reset.
            if (i_valid && (state_q != StCollect)) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StCollect;
                        x_q     <= '0;
                        y_q     <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StCollect: begin
                    if (i_valid) begin
                        if (x_q == LastPos) begin
                            x_q <= '0;
                            if (y_q == LastPos) begin
                                state_q <= StDone;
                                y_q     <= '0;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                y_q <= y_q + cnt_t'(1);
                            end
                        end else begin
                            x_q <= x_q + cnt_t'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int yi = 0; yi < OUT_W; yi++) begin
                for (int xi = 0; xi < OUT_W; xi++) begin
                    for (int c = 0; c < int'(CHANNELS); c++) begin
                        fmap_q[yi][xi][c] <= '0;
                    end
                end
            end
        end else if (wr_en) begin
            for (int yi = 0; yi < OUT_W; yi++) begin
                for (int xi = 0; xi < OUT_W; xi++) begin
                    if ((y_q == cnt_t'(yi)) && (x_q == cnt_t'(xi))) begin
                        for (int c = 0; c < int'(CHANNELS); c++) begin
                            fmap_q[yi][xi][c] <= clamped[c];
                        end
                    end
                end
            end
        end
    end

    assign fmap_out = fmap_q;
    assign i_ready  = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fmap_collector.sv
// Directed bench for fmap_collector with a 3x3x2 output map.
module tb_fmap_collector;

    localparam int W  = 5;
    localparam int OW = W - 2;
    localparam int CH = 2;
    localparam int DW = 18;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          i_valid;
    logic [DW-1:0] pixel_in [0:CH-1];
    logic          i_ready;
    logic [DW-1:0] fmap_out [0:OW-1][0:OW-1][0:CH-1];
    logic          busy;
    logic          done;
    logic          err;

    logic [DW-1:0] exp_map  [0:OW-1][0:OW-1][0:CH-1];

    int n_checks = 0;
    int n_errors = 0;

    fmap_collector #(
        .WIDTH(W),
        .DATA_WIDTH(DW),
        .CHANNELS(CH)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .i_valid(i_valid),
        .pixel_in(pixel_in),
        .i_ready(i_ready),
        .fmap_out(fmap_out),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_map(input string tag);
        for (int y = 0; y < OW; y++) begin
            for (int x = 0; x < OW; x++) begin
                for (int c = 0; c < CH; c++) begin
                    check($sformatf("%s[%0d][%0d][%0d]", tag, y, x, c),
                          32'(fmap_out[y][x][c]), 32'(exp_map[y][x][c]));
                end
            end
        end
    endtask

    task automatic clear_exp();
        for (int y = 0; y < OW; y++)
            for (int x = 0; x < OW; x++)
                for (int c = 0; c < CH; c++)
                    exp_map[y][x][c] = '0;
    endtask

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] v);
`ifdef FMAP_COLLECT_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // One full frame: start cycle, OW*OW accepts (optional gap after vector 4), DONE cycle.
    task automatic run_frame(input int off, input bit neg, input int gap_len, input bit hold);
        logic [DW-1:0] v;
        start   = 1'b1;
        i_valid = 1'b0;
        step();
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(i_ready), 32'd1);
        if (!hold) start = 1'b0;
        for (int k = 0; k < OW * OW; k++) begin
            i_valid = 1'b1;
            for (int c = 0; c < CH; c++) begin
                if (neg) v = (c == 0) ? DW'(-3) : DW'(5);
                else     v = DW'(10 * k + c + off);
                pixel_in[c] = v;
                exp_map[k / OW][k % OW][c] = stored(v);
            end
            step();
            if (k == OW * OW - 1) begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_in_done", 32'(busy), 32'd0);
                check("ready_in_done", 32'(i_ready), 32'd0);
            end else begin
                check("done_early", 32'(done), 32'd0);
            end
            if (k == 4) begin
                i_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    step();
                    check("busy_in_gap", 32'(busy), 32'd1);
                    check("done_in_gap", 32'(done), 32'd0);
                end
            end
        end
        i_valid = 1'b0;
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        i_valid = 1'b0;
        for (int c = 0; c < CH; c++) pixel_in[c] = '0;
        clear_exp();
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(i_ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check_map("rst_map");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back frame
        run_frame(0, 1'b0, 0, 1'b0);
        check_map("f1_map");
        check("f1_elem_1_2_1", 32'(fmap_out[1][2][1]), 32'd51);

        // Same frame with a 3-cycle gap
        run_frame(0, 1'b0, 3, 1'b0);
        check_map("gap_map");

        // Data while idle is dropped and flags err
        i_valid = 1'b1;
        for (int c = 0; c < CH; c++) pixel_in[c] = DW'(7);
        step();
        i_valid = 1'b0;
        check("idle_err", 32'(err), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check_map("idle_map");
        run_frame(200, 1'b0, 0, 1'b0);
        check_map("after_err_map");
        check("err_sticky", 32'(err), 32'd1);

        // Reset mid-frame after 4 accepts
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1;
            for (int c = 0; c < CH; c++) pixel_in[c] = DW'(300 + k);
            step();
        end
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        clear_exp();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ready", 32'(i_ready), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check_map("midrst_map");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(400, 1'b0, 0, 1'b0);
        check_map("restart_map");
        check("restart_err", 32'(err), 32'd0);

        // Negative/positive elements: clamp or verbatim depending on build
        run_frame(0, 1'b1, 0, 1'b0);
        check_map("neg_map");
`ifdef FMAP_COLLECT_RELU_EN
        check("neg_elem", 32'(fmap_out[2][1][0]), 32'd0);
`else
        check("neg_elem", 32'(fmap_out[2][1][0]), 32'h3fffd);
`endif
        check("pos_elem", 32'(fmap_out[2][1][1]), 32'd5);

        // start held high: second frame begins right after DONE
        run_frame(500, 1'b0, 0, 1'b1);
        run_frame(600, 1'b0, 0, 1'b1);
        start = 1'b0;
        step();
        check("hold_idle_busy", 32'(busy), 32'd0);
        check_map("hold_map");
        check("hold_elem_0_0_0", 32'(fmap_out[0][0][0]), 32'd600);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fmap_collector.md
# fmap_collector

Receiving end of the window stream feeding the layer-3 MAC array. Accepts one per-channel result vector per sliding-window position, in raster order, and writes it into a registered output feature map of (WIDTH-2) x (WIDTH-2) x CHANNELS. Signals completion once every window position of a frame has been written, so the next layer can consume the assembled map.

## Interface
- WIDTH, 28, input map width/height; output map side OUT_W = WIDTH-2 (localparam)
- DATA_WIDTH, 18, bits per element, signed two's complement
- CHANNELS, 16, output channels per window position
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin collecting a frame; sampled in IDLE only
- i_valid  input  1  result vector present on pixel_in
- pixel_in  input  [DATA_WIDTH-1:0] x [0:CHANNELS-1]  one result per channel for the current window position
- i_ready  output  1  block accepts pixel_in this cycle
- fmap_out  output  [DATA_WIDTH-1:0] x [0:OUT_W-1][0:OUT_W-1][0:CHANNELS-1]  assembled map, registered
- busy  output  1  frame collection in progress
- done  output  1  one-cycle pulse after the last element is written
- err  output  1  sticky: valid data arrived while not collecting

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE: i_ready=0. start=1 -> COLLECT, x=0, y=0.
- COLLECT: i_ready=1. On i_valid: write pixel_in[c] to fmap_out[y][x][c] for all c. Then x advances; at x=OUT_W-1, x wraps to 0 and y increments.
- A write at (x=OUT_W-1, y=OUT_W-1) -> DONE, x=y=0.
- DONE: held for exactly one cycle, done=1 -> IDLE.
- i_valid low in COLLECT: no write, counters hold. Gaps of any length are allowed.
- i_valid high in IDLE or DONE: data dropped, err set; err clears only on reset.
- start in COLLECT or DONE: ignored. start in IDLE with i_valid high: the transition occurs, data that cycle is dropped and err is set.
- fmap_out persists between frames. A new frame overwrites positions in place, with no bulk clear.
- Counters are 6 bits, sufficient for OUT_W <= 63. WIDTH > 65 is illegal.

## Timing
- Reset: state=IDLE, x=y=0, every fmap_out element=0, i_ready=0, busy=0, done=0, err=0.
- Write latency: pixel_in accepted at edge N is visible on fmap_out after edge N.
- busy = (state==COLLECT).
- done rises the cycle after the final accept; the whole map is valid from that cycle.
- Minimum frame: 1 cycle start + OUT_W*OUT_W accepts + 1 DONE cycle.
- Reset asserted mid-frame: immediate return to IDLE, map cleared, no done pulse.

## Configuration
- FMAP_COLLECT_RELU_EN defined: each element is clamped to 0 if negative (MSB=1) before storage; non-negative values pass unchanged.
- Not defined: elements are stored verbatim, including negatives.

## Structure
- Shared package fmap_pkg holds:
  - the state_t enum (IDLE, COLLECT, DONE)
  - default WIDTH/DATA_WIDTH/CHANNELS constants, shared with the window producer
  - the counter width constant (6)
- One sub-module, fmap_relu_clamp, a per-element clamp instantiated per channel. Under the macro it is a pass-through when disabled.

## Test plan
- WIDTH=5 (OUT_W=3), CHANNELS=2: start, then 9 back-to-back valids with channel c of vector k = 10*k+c -> fmap_out[1][2][1]=51, done pulses 1 cycle after the 9th accept, busy low afterwards.
- Same config, with i_valid deasserted for 3 cycles between vectors 4 and 5 -> identical final map, done timing shifted by 3 cycles.
- i_valid=1 with value 7 while IDLE -> err=1, map unchanged. A following full frame completes normally and err stays 1.
- Reset asserted after 4 accepts -> all outputs 0 immediately. Restart and run a full frame -> correct map, single done pulse.
- RELU enabled: pixel_in=-3 (all-ones upper bits) -> stored 0; pixel_in=+5 -> stored 5. With RELU disabled, -3 is stored verbatim.
- start held high across a full frame and into IDLE -> second frame begins the cycle after DONE, and the second frame overwrites the first.
